// File: rtl/uart_tx_arbiter.sv
// Frame-locked round-robin arbiter feeding the single UART transmit byte stream.
// The grant is held for a whole frame; a watchdog drops a requester that stalls mid-frame.
module uart_tx_arbiter #(
    parameter int NUM_SRC         = 2,
    parameter int BYTES_PER_FRAME = 8,
    parameter int STALL_TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_SRC-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]     s_axis_tvalid,
    output logic [NUM_SRC-1:0]     s_axis_tready,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   busy,
    output logic                   frame_abort
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int BW = $clog2(BYTES_PER_FRAME + 1);
    localparam int SW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_SRC   = IW'(NUM_SRC - 1);
    localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES_PER_FRAME - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_d;
    logic [IW-1:0]      owner, owner_d;
    logic [IW-1:0]      rr_ptr, rr_d;
    logic [IW-1:0]      pick, next_ptr, cand;
    logic               pick_vld;
    logic [NUM_SRC-1:0] grant_d;
    logic [BW-1:0]      byte_cnt, byte_d;
    logic [SW-1:0]      stall_cnt, stall_d;
    logic               abort_d;
    logic               src_vld, hs;
    logic [7:0]         sel_data;
    int                 scan;

    // Scan downward so the nearest requester at or after rr_ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan     = 0;
        cand     = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NUM_SRC) scan = scan - NUM_SRC;
            cand = scan[IW-1:0];
            if (s_axis_tvalid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (owner == IW'(i)) sel_data = s_axis_tdata[8*i +: 8];
        end
    end

    assign busy          = (state == BUSY);
    assign src_vld       = s_axis_tvalid[owner];
    assign m_axis_tvalid = busy & src_vld;
    assign m_axis_tdata  = busy ? sel_data : 8'h00;
    assign s_axis_tready = busy ? (grant & {NUM_SRC{m_axis_tready}}) : '0;
    assign hs            = m_axis_tvalid & m_axis_tready;
    assign next_ptr      = (owner == LAST_SRC) ? '0 : owner + 1'b1;

    always_comb begin
        state_d = state;
        owner_d = owner;
        grant_d = grant;
        rr_d    = rr_ptr;
        byte_d  = byte_cnt;
        stall_d = stall_cnt;
        abort_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_d       = BUSY;
                    owner_d       = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    byte_d        = '0;
                    stall_d       = '0;
                end
            end
            BUSY: begin
                if (src_vld) begin
                    stall_d = '0;
                    if (hs) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state_d = IDLE;
                            grant_d = '0;
                            rr_d    = next_ptr;
                            byte_d  = '0;
                        end else begin
                            byte_d = byte_cnt + 1'b1;
                        end
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    // Partial frame is abandoned, not replayed.
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = next_ptr;
                    byte_d  = '0;
                    stall_d = '0;
                    abort_d = 1'b1;
                end else begin
                    stall_d = stall_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            grant       <= '0;
            rr_ptr      <= '0;
            byte_cnt    <= '0;
            stall_cnt   <= '0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            grant       <= grant_d;
            rr_ptr      <= rr_d;
            byte_cnt    <= byte_d;
            stall_cnt   <= stall_d;
            frame_abort <= abort_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 2-source instance and a 4-source
// instance, both with a short stall timeout of 4 cycles.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mready = 1'b1;

    logic [15:0] a_tdata;
    logic [1:0]  a_tvalid, a_tready, a_grant;
    logic [7:0]  a_mdata;
    logic        a_mvalid, a_busy, a_abort;

    logic [31:0] b_tdata;
    logic [3:0]  b_tvalid, b_tready, b_grant;
    logic [7:0]  b_mdata;
    logic        b_mvalid, b_busy, b_abort;

    int          n_assert = 0;
    int          n_fail = 0;
    int          c[2];
    int          own;
    int          n3;
    logic [1:0]  eg;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_SRC(2), .BYTES_PER_FRAME(8), .STALL_TIMEOUT(4)
    ) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid),
        .s_axis_tready(a_tready),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid),
        .m_axis_tready(mready),
        .grant(a_grant), .busy(a_busy), .frame_abort(a_abort)
    );

    uart_tx_arbiter #(
        .NUM_SRC(4), .BYTES_PER_FRAME(8), .STALL_TIMEOUT(4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid),
        .s_axis_tready(b_tready),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid),
        .m_axis_tready(mready),
        .grant(b_grant), .busy(b_busy), .frame_abort(b_abort)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full frame from a single source on instance A, mready held high.
    task automatic frame_a(input int src, input logic [7:0] base);
        logic [1:0] g;
        g = '0;
        g[src] = 1'b1;
        a_tvalid = g;
        a_tdata[8*src +: 8] = base;
        #1;
        chk("frm_idle_busy", a_busy, 0);
        chk("frm_idle_mvalid", a_mvalid, 0);
        tick();
        for (int b = 0; b < 8; b++) begin
            a_tdata[8*src +: 8] = base + 8'(b);
            #1;
            chk("frm_grant", a_grant, g);
            chk("frm_mvalid", a_mvalid, 1);
            chk("frm_mdata", a_mdata, base + 8'(b));
            chk("frm_tready", a_tready, g);
            tick();
        end
        a_tvalid = '0;
        #1;
        chk("frm_end_busy", a_busy, 0);
        chk("frm_end_grant", a_grant, 0);
        tick();
    endtask

    task automatic drive2();
        for (int i = 0; i < 2; i++) begin
            a_tvalid[i] = (c[i] < 16);
            a_tdata[8*i +: 8] = ((i == 0) ? 8'h20 : 8'h40) + 8'(c[i]);
        end
    endtask

    initial begin
        a_tdata = '0;
        a_tvalid = '0;
        b_tdata = '0;
        b_tvalid = '0;
        tick();
        tick();
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_grant", a_grant, 0);
        chk("rst_a_abort", a_abort, 0);
        chk("rst_a_mvalid", a_mvalid, 0);
        chk("rst_a_tready", a_tready, 0);
        chk("rst_b_grant", b_grant, 0);
        chk("rst_b_busy", b_busy, 0);
        rst = 1'b0;

        // Single frame from src0.
        frame_a(0, 8'h10);

        // Both sources with two frames each, starting from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c[0] = 0;
        c[1] = 0;
        for (int f = 0; f < 4; f++) begin
            own = f % 2;
            eg = 2'b01 << own;
            drive2();
            #1;
            chk("rr_idle_busy", a_busy, 0);
            chk("rr_idle_mvalid", a_mvalid, 0);
            tick();
            for (int b = 0; b < 8; b++) begin
                drive2();
                #1;
                chk("rr_grant", a_grant, eg);
                chk("rr_mdata", a_mdata,
                    ((own == 0) ? 8'h20 : 8'h40) + 8'(c[own]));
                chk("rr_tready", a_tready, eg);
                tick();
                c[own]++;
            end
        end
        drive2();
        #1;
        chk("rr_done_busy", a_busy, 0);
        tick();

        // Src1 frame under toggling uart backpressure.
        c[1] = 0;
        a_tvalid = 2'b10;
        a_tdata[15:8] = 8'h60;
        #1;
        chk("bp_idle_busy", a_busy, 0);
        tick();
        for (int k = 0; k < 15; k++) begin
            mready = (k % 2 == 0);
            a_tdata[15:8] = 8'h60 + 8'(c[1]);
            #1;
            chk("bp_tready", a_tready, {mready, 1'b0});
            chk("bp_mvalid", a_mvalid, 1);
            chk("bp_mdata", a_mdata, 8'h60 + 8'(c[1]));
            chk("bp_abort", a_abort, 0);
            tick();
            if (mready) c[1]++;
        end
        mready = 1'b1;
        a_tvalid = '0;
        #1;
        chk("bp_end_busy", a_busy, 0);
        chk("bp_end_abort", a_abort, 0);
        tick();

        // Src0 stalls after 3 bytes while src1 waits.
        a_tvalid = 2'b11;
        a_tdata = 16'h8070;
        #1;
        chk("st_idle_busy", a_busy, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            a_tdata[7:0] = 8'h70 + 8'(b);
            #1;
            chk("st_grant", a_grant, 2'b01);
            chk("st_mdata", a_mdata, 8'h70 + 8'(b));
            tick();
        end
        a_tvalid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("st_low_busy", a_busy, 1);
            chk("st_low_abort", a_abort, 0);
            chk("st_low_mvalid", a_mvalid, 0);
            chk("st_low_grant", a_grant, 2'b01);
            tick();
        end
        #1;
        chk("st_abort", a_abort, 1);
        chk("st_ab_grant", a_grant, 0);
        chk("st_ab_busy", a_busy, 0);
        tick();
        for (int b = 0; b < 8; b++) begin
            a_tdata[15:8] = 8'h80 + 8'(b);
            #1;
            chk("st_s1_grant", a_grant, 2'b10);
            chk("st_s1_mdata", a_mdata, 8'h80 + 8'(b));
            chk("st_s1_abort", a_abort, 0);
            tick();
        end
        a_tvalid = '0;
        #1;
        chk("st_end_busy", a_busy, 0);
        tick();

        // Reset mid-frame after 5 bytes of src1; rr_ptr was 1 before.
        frame_a(0, 8'hC0);
        a_tvalid = 2'b10;
        a_tdata[15:8] = 8'hD0;
        #1;
        chk("mr_idle_busy", a_busy, 0);
        tick();
        for (int b = 0; b < 5; b++) begin
            a_tdata[15:8] = 8'hD0 + 8'(b);
            #1;
            chk("mr_grant", a_grant, 2'b10);
            chk("mr_mdata", a_mdata, 8'hD0 + 8'(b));
            tick();
        end
        a_tdata[15:8] = 8'hD5;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_tvalid = 2'b11;
        a_tdata = 16'hE0F0;
        #1;
        chk("mr_rst_busy", a_busy, 0);
        chk("mr_rst_grant", a_grant, 0);
        chk("mr_rst_abort", a_abort, 0);
        chk("mr_rst_mvalid", a_mvalid, 0);
        chk("mr_rst_tready", a_tready, 0);
        tick();
        chk("mr_win_grant", a_grant, 2'b01);
        chk("mr_win_mdata", a_mdata, 8'hF0);
        chk("mr_win_abort", a_abort, 0);
        a_tvalid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Four sources, only src3 requesting repeatedly.
        n3 = 0;
        b_tvalid = 4'b1000;
        for (int f = 0; f < 3; f++) begin
            b_tdata[31:24] = 8'hA0 + 8'(n3);
            #1;
            chk("s3_idle_busy", b_busy, 0);
            chk("s3_idle_mvalid", b_mvalid, 0);
            chk("s3_idle_tready", b_tready, 0);
            tick();
            for (int b = 0; b < 8; b++) begin
                b_tdata[31:24] = 8'hA0 + 8'(n3);
                #1;
                chk("s3_grant", b_grant, 4'b1000);
                chk("s3_mdata", b_mdata, 8'hA0 + 8'(n3));
                chk("s3_tready", b_tready, 4'b1000);
                tick();
                n3++;
            end
        end
        b_tvalid = '0;
        #1;
        chk("s3_end_busy", b_busy, 0);
        chk("s3_end_grant", b_grant, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
